// File: rtl/ifid_queue_pkg.sv
// Shared definitions for the fetch-to-decode queue: NOP encoding, default depth,
// entry layout and the occupancy-state encoding exposed for debug.
package ifid_queue_pkg;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam int          IFQ_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    typedef enum logic [1:0] {
        Q_EMPTY   = 2'd0,
        Q_PARTIAL = 2'd1,
        Q_FULL    = 2'd2
    } ifq_state_e;

endpackage

// File: rtl/ifid_queue_if.sv
// One instruction stream link: {inst, pc} with a valid/ready handshake.
// A word transfers on a rising edge where valid && ready; ready never depends on valid.
interface ifid_queue_if;

    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        ready;

    modport master (output inst, output pc, output valid, input ready);
    modport slave  (input inst, input pc, input valid, output ready);

endinterface

// File: rtl/ifid_queue.sv
// Circular buffer decoupling fetch from decode; flush squashes all entries and
// decode sees a NOP bubble whenever the queue is empty.
module ifid_queue
    import ifid_queue_pkg::*;
#(
    parameter int DEPTH = IFQ_DEPTH,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ifid_queue_if.slave              in_bus,
    ifid_queue_if.master             out_bus,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cycles,
    output ifq_state_e               state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ifq_entry_t    mem [DEPTH];
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic          full;
    logic          not_empty;
    logic          push;
    logic          pop;
    ifq_entry_t    head;

    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = in_bus.valid && !full && !flush;
    assign pop       = not_empty && out_bus.ready && !flush;

    // ready is taken from occupancy alone so a full queue refuses even when popping
    assign in_bus.ready = !full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop)  rp <= rp + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (not_empty && !out_bus.ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Entry storage needs no reset: it is only read while count says it is live
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= '{pc: in_bus.pc, inst: in_bus.inst};
        end
    end

    assign head = mem[rp];

    always_comb begin
        out_bus.valid = not_empty;
        out_bus.inst  = NOP;
        out_bus.pc    = '0;
        if (not_empty) begin
            out_bus.inst = head.inst;
            out_bus.pc   = head.pc;
        end
    end

    always_comb begin
        state = Q_EMPTY;
        if (full)           state = Q_FULL;
        else if (not_empty) state = Q_PARTIAL;
    end

endmodule

// File: tb/tb_ifid_queue.sv
// Self-checking bench for ifid_queue: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_ifid_queue;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;
  logic flush;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] stall_cycles;
  ifid_queue_pkg::ifq_state_e state;

  ifid_queue_if in_if ();
  ifid_queue_if out_if ();

  ifid_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (in_if),
    .out_bus      (out_if),
    .flush        (flush),
    .count        (count),
    .stall_cycles (stall_cycles),
    .state        (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: FIFO contents as {pc, inst} and saturating stall count
  logic [63:0] exp_q[$];
  int exp_stall;
  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_outputs();
    logic        ev;
    logic [63:0] head;
    ev   = (exp_q.size() != 0);
    head = ev ? exp_q[0] : 64'h0;
    check("out_valid", {63'h0, out_if.valid}, {63'h0, ev});
    check("out_inst", {32'h0, out_if.inst}, {32'h0, head[31:0]});
    check("out_pc", {32'h0, out_if.pc}, {32'h0, head[63:32]});
    check("in_ready", {63'h0, in_if.ready}, {63'h0, exp_q.size() < DEPTH});
    check("count", 64'(count), 64'(exp_q.size()));
    check("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
    check("state", 64'(state), (exp_q.size() == DEPTH) ? 64'd2 : (exp_q.size() != 0) ? 64'd1 : 64'd0);
  endtask

  // driver: called at a negedge; checks, drives, advances the model, returns at next negedge
  task automatic drive_cycle(input logic iv, input logic [31:0] ipc, input logic ordy, input logic fl);
    logic [31:0] inst;
    int  sz;
    bit  can_push;
    bit  has_head;
    check_outputs();
    inst         = $urandom;
    in_if.valid  = iv;
    in_if.pc     = ipc;
    in_if.inst   = inst;
    out_if.ready = ordy;
    flush        = fl;
    sz       = exp_q.size();
    can_push = (sz < DEPTH);
    has_head = (sz > 0);
    if (has_head && !ordy && exp_stall < STALL_MAX) exp_stall++;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (has_head && ordy) void'(exp_q.pop_front());
      if (iv && can_push) exp_q.push_back({ipc, inst});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    exp_stall = 0;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    exp_stall    = 0;
    rst          = 1'b0;
    flush        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.pc     = '0;
    in_if.inst   = '0;
    out_if.ready = 1'b0;
    @(negedge clk);
    apply_reset();

    // reset then idle
    repeat (2) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // stream: each word one cycle later, count stays at most 1
    drive_cycle(1'b1, 32'h0, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h4, 1'b1, 1'b0);
    drive_cycle(1'b1, 32'h8, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // stall fill: third push held off, then release drains in order
    drive_cycle(1'b1, 32'h10, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h14, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h18, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h18, 1'b0, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // full with simultaneous pop: pop happens, push refused
    drive_cycle(1'b1, 32'h20, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h24, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h28, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // flush at full with a word presented: 0x40 discarded, 0x80 next
    drive_cycle(1'b1, 32'h30, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h34, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h40, 1'b1, 1'b1);
    drive_cycle(1'b1, 32'h80, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // wrap: five words with an occasional stall
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 32'h100 + 32'(i * 4), (i != 2), 1'b0);
    repeat (3) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 3) != 0, {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    // asynchronous reset mid-cycle with a non-empty queue
    drive_cycle(1'b1, 32'h200, 1'b0, 1'b0);
    drive_cycle(1'b1, 32'h204, 1'b0, 1'b0);
    check_outputs();
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_stall = 0;
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive_cycle(1'b1, 32'h300, 1'b1, 1'b0);
    drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
